// File: rtl/ua_transmitter.sv
// ua_transmitter: 8N1 UART transmitter driven by a shared baud x OVERSAMPLE
// enable tick. A one-byte holding register lets the next byte queue up while
// the current frame shifts out, so consecutive frames go out back-to-back.
module ua_transmitter #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] din_byte,
    input  logic       din_wr,
    output logic       din_rdy,
    output logic       ser_out,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_overrun
);

    // Elaboration-time guards on the parameter ranges the datapath supports.
    if (DATA_BITS != 8) begin : g_bad_data_bits
        $error("ua_transmitter: DATA_BITS must be 8");
    end
    if (OVERSAMPLE < 2 || OVERSAMPLE > 16) begin : g_bad_oversample
        $error("ua_transmitter: OVERSAMPLE must be in 2..16");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("ua_transmitter: STOP_BITS must be 1 or 2");
    end

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] BIT_LAST  = 3'd7;
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    logic [2:0] state_q, state_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       ser_out_q, ser_out_d;
    logic       done_q, done_d;
    logic       overrun_q, overrun_d;
    logic       load;
    logic       accept;

    // Next-state logic: bit timing advances on enable ticks, holder writes on any clk.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        ser_out_d   = ser_out_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q;
        load        = 1'b0;

        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    ser_out_d = 1'b1;
                    if (hold_full_q) begin
                        load       = 1'b1;
                        state_d    = ST_START;
                        tick_cnt_d = 4'd0;
                        shift_d    = hold_q;
                        ser_out_d  = 1'b0;
                    end
                end
                ST_START: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        state_d    = ST_DATA;
                        tick_cnt_d = 4'd0;
                        bit_cnt_d  = 3'd0;
                        ser_out_d  = shift_q[0];
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
                ST_DATA: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = 4'd0;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d   = ST_STOP;
                            bit_cnt_d = 3'd0;
                            ser_out_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            shift_d   = {1'b0, shift_q[7:1]};
                            ser_out_d = shift_q[1];
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
                ST_STOP: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = 4'd0;
                        if (bit_cnt_q == STOP_LAST) begin
                            // Frame complete; chain straight into the next one if queued.
                            bit_cnt_d = 3'd0;
                            done_d    = 1'b1;
                            if (hold_full_q) begin
                                load      = 1'b1;
                                state_d   = ST_START;
                                shift_d   = hold_q;
                                ser_out_d = 1'b0;
                            end else begin
                                state_d   = ST_IDLE;
                                ser_out_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    tick_cnt_d = 4'd0;
                    bit_cnt_d  = 3'd0;
                    ser_out_d  = 1'b1;
                end
            endcase
        end

        // The holder empties on a load, and a write in that same cycle refills it.
        accept = din_wr && (!hold_full_q || load);
        if (load) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_d      = din_byte;
            hold_full_d = 1'b1;
        end else if (din_wr) begin
            overrun_d = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset; reset aborts any frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= 4'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            ser_out_q   <= 1'b1;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ser_out_q   <= ser_out_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign din_rdy    = !hold_full_q;
    assign ser_out    = ser_out_q;
    assign tx_busy    = (state_q != ST_IDLE);
    assign tx_done    = done_q;
    assign tx_overrun = overrun_q;

endmodule

// File: tb/tb_ua_transmitter.sv
// tb_ua_transmitter: scoreboard bench for ua_transmitter. Accepted bytes are
// queued as expectations; a loop-back receiver decodes the line tick by tick
// and compares each decoded frame against the queue.
module tb_ua_transmitter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] din_byte = 8'd0;
    logic       din_wr = 1'b0;
    logic       din_rdy, ser_out, tx_busy, tx_done, tx_overrun;

    logic [7:0] din_byte2 = 8'd0;
    logic       din_wr2 = 1'b0;
    logic       din_rdy2, ser_out2, tx_busy2, tx_done2, tx_overrun2;

    localparam int OS        = 16;
    localparam int FRAME_LEN = 10 * OS;

    always #5 clk = ~clk;

    ua_transmitter #(.OVERSAMPLE(OS), .DATA_BITS(8), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .din_byte(din_byte), .din_wr(din_wr),
        .din_rdy(din_rdy), .ser_out(ser_out), .tx_busy(tx_busy), .tx_done(tx_done),
        .tx_overrun(tx_overrun)
    );

    ua_transmitter #(.OVERSAMPLE(OS), .DATA_BITS(8), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .din_byte(din_byte2), .din_wr(din_wr2),
        .din_rdy(din_rdy2), .ser_out(ser_out2), .tx_busy(tx_busy2), .tx_done(tx_done2),
        .tx_overrun(tx_overrun2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Enable tick generator: every 4th clk, random density, or held low.
    bit en_hold = 1'b0;
    int en_mode = 0;
    initial begin : en_gen
        int phase;
        phase = 0;
        forever begin
            @(negedge clk);
            phase++;
            if (en_hold) enable = 1'b0;
            else if (en_mode == 0) enable = (phase % 4 == 0);
            else enable = ($urandom_range(2) == 0);
        end
    end

    // Scoreboard state shared between stimulus and monitor.
    logic [7:0] exp_q[$];
    int frames_done    = 0;
    int frames_started = 0;
    int done_cnt       = 0;
    bit last_b2b       = 1'b0;

    // Loop-back receiver: one line sample per enable tick, full-frame decode.
    initial begin : monitor
        bit             in_frame;
        bit             b2b;
        bit             e;
        bit             shape_ok;
        int             idx;
        logic [FRAME_LEN-1:0] fb;
        logic [7:0]     b;
        in_frame = 1'b0;
        b2b      = 1'b0;
        idx      = 0;
        fb       = '0;
        forever begin
            @(posedge clk);
            e = enable;
            @(negedge clk);
            if (!rst) begin
                in_frame = 1'b0;
                idx      = 0;
                exp_q.delete();
                continue;
            end
            if (tx_done) done_cnt++;
            if (!e) continue;
            if (!in_frame) begin
                if (ser_out == 1'b0) begin
                    in_frame = 1'b1;
                    fb[0]    = 1'b0;
                    idx      = 1;
                    b2b      = 1'b0;
                    frames_started++;
                end
            end else if (idx < FRAME_LEN) begin
                fb[idx] = ser_out;
                idx++;
            end else begin
                check("tx_done_at_frame_end", tx_done, 1);
                shape_ok = 1'b1;
                b        = 8'd0;
                for (int i = 0; i < OS; i++) if (fb[i] !== 1'b0) shape_ok = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    b[k] = fb[OS + OS * k];
                    for (int j = 0; j < OS; j++)
                        if (fb[OS + OS * k + j] !== b[k]) shape_ok = 1'b0;
                end
                for (int i = 9 * OS; i < FRAME_LEN; i++) if (fb[i] !== 1'b1) shape_ok = 1'b0;
                check("frame_shape", shape_ok, 1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_frame: got 0x%0h, expected no frame", b);
                end else begin
                    check("frame_byte", b, exp_q.pop_front());
                end
                last_b2b = b2b;
                frames_done++;
                if (ser_out == 1'b0) begin
                    fb[0] = 1'b0;
                    idx   = 1;
                    b2b   = 1'b1;
                    frames_started++;
                end else begin
                    in_frame = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!din_rdy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!din_rdy) begin
            timeout_fail("din_rdy_wait");
        end else begin
            din_byte = b;
            din_wr   = 1'b1;
            exp_q.push_back(b);
            @(negedge clk);
            din_wr = 1'b0;
        end
    endtask

    task automatic write_raw(input logic [7:0] b);
        @(negedge clk);
        din_byte = b;
        din_wr   = 1'b1;
        @(negedge clk);
        din_wr = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int c;
        c = 0;
        while (frames_done < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (frames_done < n) timeout_fail("wait_frames");
    endtask

    task automatic wait_line_low();
        int c;
        c = 0;
        while (ser_out && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (ser_out) timeout_fail("start_bit_wait");
    endtask

    task automatic wait_ticks(input int n);
        int t;
        t = 0;
        while (t < n) begin
            @(posedge clk);
            if (enable) t++;
        end
    endtask

    initial begin : stimulus
        int saved_started, saved_done_cnt;
        int low_cnt, high_cnt, c;
        bit started, got_done, e;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_ser_out", ser_out, 1);
        check("rst_din_rdy", din_rdy, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_tx_overrun", tx_overrun, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame 0x55, enable every 4th clk.
        send(8'h55);
        wait_line_low();
        check("start_latency", ser_out, 0);
        check("din_rdy_in_frame", din_rdy, 1);
        check("tx_busy_in_frame", tx_busy, 1);
        wait_frames(1, 2000);
        check("din_rdy_after_frame", din_rdy, 1);
        check("tx_done_count_t1", done_cnt, 1);

        // Second byte queued during DATA goes out back-to-back.
        send(8'hA3);
        repeat (120) @(negedge clk);
        send(8'h0F);
        wait_frames(3, 3000);
        check("back_to_back", last_b2b, 1);
        check("overrun_clear_t2", tx_overrun, 0);

        // Third write with full holder is dropped and flagged.
        send(8'h01);
        send(8'h02);
        write_raw(8'h03);
        check("overrun_set", tx_overrun, 1);
        wait_frames(5, 4000);
        repeat (800) @(negedge clk);
        check("overrun_sticky", tx_overrun, 1);
        check("no_dropped_frame", frames_started, 5);

        // Reset during DATA bit 4 of 0xFF with another byte queued.
        send(8'hFF);
        wait_line_low();
        send(8'h5A);
        wait_ticks(84);
        #2;
        rst = 1'b0;
        #1;
        check("midframe_rst_ser_out", ser_out, 1);
        check("midframe_rst_din_rdy", din_rdy, 1);
        check("midframe_rst_tx_busy", tx_busy, 0);
        check("midframe_rst_tx_done", tx_done, 0);
        check("midframe_rst_overrun", tx_overrun, 0);
        saved_started  = frames_started;
        saved_done_cnt = done_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (800) @(negedge clk);
        check("no_frame_after_rst", frames_started, saved_started);
        check("no_done_after_rst", done_cnt, saved_done_cnt);
        check("idle_line_after_rst", ser_out, 1);

        // Long enable gap in the middle of the start bit.
        send(8'hC6);
        wait_line_low();
        wait_ticks(5);
        en_hold = 1'b1;
        repeat (1000) @(negedge clk);
        en_hold = 1'b0;
        wait_frames(6, 3000);

        // Random bytes with random enable density and idle gaps.
        en_mode = 1;
        for (int i = 0; i < 10; i++) begin
            send(8'($urandom));
            repeat ($urandom_range(0, 300)) @(negedge clk);
        end
        wait_frames(16, 20000);
        en_mode = 0;
        check("tx_done_count_total", done_cnt, frames_done);
        check("queue_drained", exp_q.size(), 0);

        // Two stop bits: 0x00 is low for 9 bits, then high for 2 bits before tx_done.
        @(negedge clk);
        din_byte2 = 8'h00;
        din_wr2   = 1'b1;
        @(negedge clk);
        din_wr2  = 1'b0;
        low_cnt  = 0;
        high_cnt = 0;
        c        = 0;
        started  = 1'b0;
        got_done = 1'b0;
        while (c < 4000 && !got_done) begin
            @(posedge clk);
            e = enable;
            @(negedge clk);
            c++;
            if (e) begin
                if (tx_done2) got_done = 1'b1;
                else if (ser_out2 == 1'b0) begin
                    started = 1'b1;
                    low_cnt++;
                end else if (started) high_cnt++;
            end
        end
        if (!got_done) timeout_fail("stop2_tx_done");
        check("stop2_low_ticks", low_cnt, 9 * OS);
        check("stop2_high_ticks", high_cnt, 2 * OS);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
